// File: rtl/multdiv_pkg.sv
// Shared definitions for the mult/div controller and the status-register
// write logic: FSM state encoding and the exception status codes.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int STATUS_NONE     = 0;
    localparam int STATUS_MULT_EXC = 1;
    localparam int STATUS_DIV_EXC  = 2;

    // Status code reported for an exception of the given operation type.
    function automatic int exc_status(input logic is_div);
        return is_div ? STATUS_DIV_EXC : STATUS_MULT_EXC;
    endfunction

    // Counter width able to hold 0..timeout-1; never narrower than one bit.
    function automatic int counter_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/multdiv_controller_counter.sv
// Wait-cycle counter: synchronous clear, count enable, and a terminal flag
// raised while the count sits at TIMEOUT-1.
module cycle_counter
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int            CW   = counter_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority over enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
        terminal = (count_q == LAST);
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_controller.sv
// Execute-stage controller for an iterative multiply/divide unit: accepts an
// operation, stalls the front of the pipeline, launches and supervises the
// datapath (timeout and flush abort) and presents the result for one cycle.
module multdiv_controller
    import multdiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             unit_start,
    output logic             unit_is_div,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic             unit_abort,
    input  logic             unit_ready,
    input  logic [WIDTH-1:0] unit_result,
    input  logic             unit_exception,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [WIDTH-1:0] status_code
);

    state_e           state_q, state_d;
    logic             unit_is_div_q, unit_is_div_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d;
    logic [WIDTH-1:0] unit_b_q, unit_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic [WIDTH-1:0] status_q, status_d;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_terminal;

    cycle_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (cnt_terminal)
    );

    // FSM next state, register updates and combinational control outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        unit_is_div_d = unit_is_div_q;
        unit_a_d      = unit_a_q;
        unit_b_d      = unit_b_q;
        result_d      = result_q;
        exc_d         = exc_q;
        status_d      = status_q;
        cnt_clear     = 1'b0;
        cnt_enable    = 1'b0;
        unit_start    = 1'b0;
        unit_abort    = 1'b0;
        stall         = 1'b0;
        result_valid  = 1'b0;
        exception     = exc_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    stall = 1'b1;
                    if (op_is_div && (operand_b == '0)) begin
                        // Divide by zero never reaches the datapath.
                        result_d = '0;
                        exc_d    = 1'b1;
                        status_d = WIDTH'(STATUS_DIV_EXC);
                        state_d  = ST_DONE;
                    end else begin
                        unit_is_div_d = op_is_div;
                        unit_a_d      = operand_a;
                        unit_b_d      = operand_b;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    unit_abort = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stall      = 1'b1;
                    unit_start = 1'b1;
                    cnt_clear  = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    unit_abort = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stall      = 1'b1;
                    cnt_enable = 1'b1;
                    if (unit_ready) begin
                        // Completion beats a coincident timeout.
                        result_d = unit_result;
                        exc_d    = unit_exception;
                        status_d = unit_exception ? WIDTH'(exc_status(unit_is_div_q))
                                                  : WIDTH'(STATUS_NONE);
                        state_d  = ST_DONE;
                    end else if (cnt_terminal) begin
                        unit_abort = 1'b1;
                        result_d   = '0;
                        exc_d      = 1'b1;
                        status_d   = WIDTH'(exc_status(unit_is_div_q));
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                result_valid = !flush;
                if (flush) begin
                    exception = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The state clears asynchronously, but op_valid may still be high.
        if (reset) begin
            stall = 1'b0;
        end
    end

    // State, latched operation and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            unit_is_div_q <= 1'b0;
            unit_a_q      <= '0;
            unit_b_q      <= '0;
            result_q      <= '0;
            exc_q         <= 1'b0;
            status_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            unit_is_div_q <= unit_is_div_d;
            unit_a_q      <= unit_a_d;
            unit_b_q      <= unit_b_d;
            result_q      <= result_d;
            exc_q         <= exc_d;
            status_q      <= status_d;
        end
    end

    assign unit_is_div = unit_is_div_q;
    assign unit_a      = unit_a_q;
    assign unit_b      = unit_b_q;
    assign result      = result_q;
    assign status_code = status_q;

endmodule

// File: doc/multdiv_controller.md
MULTDIV_CONTROLLER -- requirements
Module: multdiv_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 40, maximum cycles in WAIT before forced abort.
REQ-003 SHALL have ports clock (in, 1) and reset (in, 1). Single clock; reset asynchronous, active-high.
REQ-004 SHALL have op_valid (in, 1): execute-stage instruction is mul/div.
REQ-005 SHALL have op_is_div (in, 1): 1 = divide, 0 = multiply.
REQ-006 SHALL have operand_a and operand_b (in, WIDTH each): bypassed ALU operands.
REQ-007 SHALL have flush (in, 1): squash the current operation (branch/jump kill).
REQ-008 SHALL have unit_start (out, 1): one-cycle start pulse to the iterative mult/div datapath.
REQ-009 SHALL have unit_is_div (out, 1), unit_a (out, WIDTH) and unit_b (out, WIDTH): latched operation.
REQ-010 SHALL have unit_abort (out, 1): one-cycle pulse that cancels the datapath.
REQ-011 SHALL have unit_ready (in, 1), unit_result (in, WIDTH) and unit_exception (in, 1): datapath completion pulse, result and overflow flag.
REQ-012 SHALL have stall (out, 1): freeze the PC, fetch/decode latch and decode/execute latch.
REQ-013 SHALL have result_valid (out, 1), result (out, WIDTH), exception (out, 1) and status_code (out, WIDTH): completion outputs.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE, op_valid=1, flush=0, op_is_div=1, operand_b=0: SHALL go to DONE with result=0, exception=1, status_code=2, and SHALL NOT pulse unit_start.
REQ-016 IDLE, op_valid=1, flush=0, all other cases: SHALL latch operands and op_is_div into unit_* registers and go to ISSUE.
REQ-017 ISSUE: SHALL assert unit_start for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-018 WAIT: SHALL increment the counter each cycle.
REQ-019 WAIT, unit_ready=1: SHALL capture unit_result and unit_exception and go to DONE.
REQ-020 status_code SHALL be 1 on a multiply exception, 2 on a divide exception, 0 otherwise.
REQ-021 WAIT, counter==TIMEOUT-1 without unit_ready: SHALL pulse unit_abort, set result=0, exception=1, status_code per REQ-020, and go to DONE.
REQ-022 unit_ready and timeout in the same cycle: unit_ready SHALL win and unit_abort SHALL NOT pulse.
REQ-023 DONE: SHALL assert result_valid for exactly one cycle with stall=0, then go to IDLE unconditionally. The pipeline advances at that edge, so the same instruction SHALL NOT re-trigger.
REQ-024 stall SHALL equal ((IDLE & op_valid) | ISSUE | WAIT) & ~flush. It is combinational, so the first cycle of an operation stalls.
REQ-025 flush in ISSUE or WAIT: SHALL pulse unit_abort and go to IDLE with no result_valid.
REQ-026 flush in IDLE: SHALL ignore op_valid.
REQ-027 flush in DONE: SHALL suppress result_valid and exception.
REQ-028 unit_ready outside WAIT SHALL be ignored.
REQ-029 result, exception and status_code SHALL hold their value until the next DONE and are meaningful only when result_valid=1.
REQ-030 Latency, multiply/divide with unit ready k cycles after unit_start: result_valid SHALL assert k+2 cycles after operation acceptance.
REQ-031 Latency, divide-by-zero: result_valid SHALL assert 1 cycle after acceptance.

Reset
REQ-032 reset SHALL force state IDLE and counter 0 immediately, without waiting for a clock edge.
REQ-033 reset SHALL drive all outputs to 0: unit_start, unit_abort, stall, result_valid, exception, result, status_code, unit_a, unit_b, unit_is_div.
REQ-034 reset mid-operation SHALL discard the operation and SHALL NOT pulse unit_abort; the datapath is reset by the same signal.

Structure
REQ-035 The state encoding, STATUS_MULT_EXC=1 and STATUS_DIV_EXC=2 SHALL live in a shared package also used by the status-register write logic.
REQ-036 The wait counter SHALL be one sub-module, cycle_counter: clear, enable, terminal-count output, width clog2(TIMEOUT).
REQ-037 The FSM, operand registers and result registers SHALL remain in multdiv_controller.

Verification
REQ-038 Multiply: op_valid, mul 7*6, unit_ready 3 cycles after unit_start with result 42 -> one unit_start; stall high for 5 cycles; result_valid with result=42, exception=0, status_code=0.
REQ-039 Divide by zero: op_valid, div 100/0 -> no unit_start; stall 1 cycle; next cycle result_valid, result=0, exception=1, status_code=2.
REQ-040 Timeout: mul with unit_ready never asserted, TIMEOUT=40 -> unit_abort pulse on WAIT cycle 40; result_valid, exception=1, status_code=1.
REQ-041 Flush: div 9/3, flush asserted 2 cycles into WAIT -> unit_abort pulse, stall drops same cycle, no result_valid; a later unit_ready is ignored.
REQ-042 Back-to-back: mul then div 20/4 (ready 2 cycles each) -> results 42 then 5, two unit_start pulses, no duplicate result_valid.
REQ-043 Reset: reset asserted during WAIT -> stall=0 and state IDLE before the next clock edge; the next op proceeds normally.
